// File: rtl/usr_shift_pkg.sv
// ---------------------------------------------------------------------------
// usr_shift_pkg
//   Shared definitions for the universal shift register serial receiver.
//   - Shift direction encodings.
//   - Receiver FSM state encodings and the state type built from them.
//   Ports: none (package only).
// ---------------------------------------------------------------------------
package usr_shift_pkg;

  // Shift direction values carried on ser_dir
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Receiver state encodings
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_PAR_ENC   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_SHIFT = ST_SHIFT_ENC,
    S_PAR   = ST_PAR_ENC
  } state_t;

endpackage

// File: rtl/usr_deser_core.sv
// ---------------------------------------------------------------------------
// usr_deser_core
//   Direction-aware shift register plus bit counter for the serial receiver.
//   Produces the word as it will look after the current bit is shifted in, and
//   a done strobe on the cycle that presents the last data bit of a word.
// Ports
//   clk          in   1      rising-edge clock
//   async_rst_n  in   1      asynchronous active-low reset
//   i_bit_en     in   1      i_bit is a data bit to shift in this cycle
//   i_bit        in   1      serial data bit
//   i_dir        in   1      direction request, used only on bit 0 of a word
//   i_restart    in   1      discard partial word; a coincident bit becomes bit 0
//   o_word       out  DW     shift register contents including the current bit
//   o_bit_cnt    out  CNT_W  bits received in the current word
//   o_done       out  1      current bit completes a word
// ---------------------------------------------------------------------------
module usr_deser_core
  import usr_shift_pkg::*;
#(
  parameter int DW    = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             i_bit_en,
  input  logic             i_bit,
  input  logic             i_dir,
  input  logic             i_restart,
  output logic [DW-1:0]    o_word,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DW - 1);

  logic [DW-1:0]    r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;

  logic             w_first;
  logic             w_dir;
  logic [DW-1:0]    w_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic [DW-1:0]    w_shifted;

  // A restart behaves as if the counter and register were already cleared, so
  // a bit arriving with it is treated as bit 0 and latches a fresh direction.
  assign w_first    = i_restart | (r_cnt == '0);
  assign w_dir      = w_first ? i_dir : r_dir;
  assign w_base     = i_restart ? '0 : r_sr;
  assign w_cnt_base = i_restart ? '0 : r_cnt;

  assign w_shifted = (w_dir == DIR_LEFT) ? {w_base[DW-2:0], i_bit}
                                         : {i_bit, w_base[DW-1:1]};

  assign o_word    = w_shifted;
  assign o_bit_cnt = r_cnt;
  assign o_done    = i_bit_en & (w_cnt_base == LAST_BIT);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_dir <= DIR_LEFT;
    end else if (i_bit_en) begin
      r_sr  <= w_shifted;
      r_cnt <= o_done ? '0 : w_cnt_base + 1'b1;
      if (w_first) begin
        r_dir <= i_dir;
      end
    end else if (i_restart) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/univ_shift_deser.sv
// ---------------------------------------------------------------------------
// univ_shift_deser
//   Serial-in/parallel-out receiver for the universal shift register link.
//   Assembles DW-bit words in either shift direction and presents them on a
//   valid/ready holding register with a sticky overrun flag.
//   Optional feature macro: USR_DESER_PARITY_EN adds one even-parity bit after
//   each word; a bad word is discarded and parity_err pulses for one cycle.
// Ports
//   clk          in   1      rising-edge clock
//   async_rst_n  in   1      asynchronous active-low reset
//   ser_en       in   1      ser_in carries a valid bit this cycle
//   ser_in       in   1      serial data bit
//   ser_dir      in   1      0 = left (enters LSB), 1 = right (enters MSB)
//   frame_start  in   1      discard partial word and restart at bit 0
//   q_ready      in   1      consumer accepts q this cycle
//   clr_ovr      in   1      clears the sticky overrun flag
//   q            out  DW     assembled word
//   q_valid      out  1      q holds an unconsumed word
//   overrun      out  1      sticky: a completed word was dropped
//   bit_cnt      out  CNT_W  bits received in the current word
//   parity_err   out  1      parity mismatch pulse (0 without the macro)
// ---------------------------------------------------------------------------
module univ_shift_deser
  import usr_shift_pkg::*;
#(
  parameter int DW    = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             ser_dir,
  input  logic             frame_start,
  input  logic             q_ready,
  input  logic             clr_ovr,
  output logic [DW-1:0]    q,
  output logic             q_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err
);

  state_t        r_state;
  logic [DW-1:0] r_q;
  logic          r_q_valid;
  logic          r_overrun;

  logic          w_bit_en;
  logic          w_done;
  logic [DW-1:0] w_word;
  logic          w_complete;
  logic [DW-1:0] w_new_word;
  logic          w_drop;

`ifdef USR_DESER_PARITY_EN
  logic [DW-1:0] r_par_word;
  logic          r_parity_err;
  logic          w_par_bit;
  logic          w_par_ok;

  // The bit after a full word is parity, not data, unless a restart claims it.
  assign w_par_bit  = (r_state == S_PAR) & ser_en & ~frame_start;
  assign w_par_ok   = ~^{r_par_word, ser_in};
  assign w_bit_en   = ser_en & (frame_start | (r_state != S_PAR));
  assign w_complete = w_par_bit & w_par_ok;
  assign w_new_word = r_par_word;
  assign parity_err = r_parity_err;
`else
  assign w_bit_en   = ser_en;
  assign w_complete = w_done;
  assign w_new_word = w_word;
  assign parity_err = 1'b0;
`endif

  // A word finishing while the holding register is full and not being read
  // has nowhere to go.
  assign w_drop = w_complete & r_q_valid & ~q_ready;

  usr_deser_core #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .i_bit_en    (w_bit_en),
    .i_bit       (ser_in),
    .i_dir       (ser_dir),
    .i_restart   (frame_start),
    .o_word      (w_word),
    .o_bit_cnt   (bit_cnt),
    .o_done      (w_done)
  );

  // Receiver FSM with the output holding register, overrun and parity flags.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_q_valid    <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef USR_DESER_PARITY_EN
      r_par_word   <= '0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (frame_start) begin
        r_state <= ser_en ? S_SHIFT : S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ser_en) begin
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (w_done) begin
`ifdef USR_DESER_PARITY_EN
              r_state <= S_PAR;
`else
              r_state <= S_IDLE;
`endif
            end
          end
          S_PAR: begin
            if (ser_en) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_complete) begin
        if (!w_drop) begin
          r_q       <= w_new_word;
          r_q_valid <= 1'b1;
        end
      end else if (r_q_valid && q_ready) begin
        r_q_valid <= 1'b0;
      end

      // A new overrun outranks a coincident clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end

`ifdef USR_DESER_PARITY_EN
      if (w_done) begin
        r_par_word <= w_word;
      end
      r_parity_err <= w_par_bit & ~w_par_ok;
`endif
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign overrun = r_overrun;

endmodule
